lzs_decode_engine: RTL and testbench
====================================

Name: lzs_decode_engine

Overview:
Parametrised next-generation LZS decompression controller. Parses the bit-aligned LZS token stream from the upstream bit-shifter: literals, short and long offset matches, extended lengths and the end marker. It emits decoded bytes on a valid/ready output port with real backpressure and keeps its own history window. It sits between the stream bit-shifter and the output FIFO, and adds sliding-window sizing, overlap-safe copy, frame-level error detection and full-length accumulation.

Parameters:
HIST_AW, 11, history address width; window = 2^HIST_AW bytes; legal 8..13.
LEN_W, 16, match length accumulator width; legal 8..16.
Derived, package only: IN_W = HIST_AW+2, the stream_data width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ce  in  1  frame enable; rising entry starts a new frame
stream_data  in  IN_W  next IN_W stream bits, MSB = oldest
stream_valid  in  1  stream_data holds at least IN_W valid bits
stream_width  out  4  bits consumed; meaningful only with stream_ack
stream_ack  out  1  consume stream_width bits this cycle
out_data  out  8  decoded byte
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts byte
out_done  out  1  end marker reached, frame clean
err  out  1  sticky frame error
err_code  out  2  01 offset zero; 10 offset beyond written bytes; 11 length overflow

Behaviour:
- Single clock clk. rst is asynchronous and active-high. Reset values: all outputs 0, state IDLE, written-byte count 0.
- FSM states: IDLE, PROC, LEN1, LEN2, LENX, COPY, END, ERR.
- IDLE: goes to PROC when ce=1. Clears the written count, so each frame starts with an empty window.
- PROC is entered only when the output skid buffer has a free slot.
- PROC, top 9 bits = 110000000: ack width 9, go to END.
- PROC, MSB 0 (literal): ack width 9, push byte = bits[IN_W-2:IN_W-9].
- PROC, "11" prefix: 7-bit offset, ack width 9, go to LEN1.
- PROC, "10" prefix: HIST_AW-bit offset, ack width HIST_AW+2, go to LEN1.
- Offset checks, made at the PROC ack: offset 0 sets err_code 01; offset greater than the written count sets err_code 10. Either error goes to ERR.
- The written count saturates at 2^HIST_AW.
- LEN1, 2 bits: 00, 01, 10 give lengths 2, 3, 4, ack width 2, go to COPY. 11 acks width 2 and goes to LEN2.
- LEN2, 2 bits: 00, 01, 10 give lengths 5, 6, 7, go to COPY. 11 sets length 8 and goes to LENX.
- LENX, 4-bit nibble N: ack width 4, length += N. N=15 stays in LENX; otherwise go to COPY.
- Length overflow past 2^LEN_W-1 sets err_code 11 and goes to ERR.
- COPY: read address = waddr - offset (mod 2^HIST_AW). Issues one history read per cycle while the skid buffer is not full, decrementing the remaining length.
- History RAM read latency is 1 cycle.
- Overlap (offset < length): a read of the address being written in the same cycle is bypassed from write data. Offset 1 therefore replicates a byte.
- Every byte pushed to the output (literal or copy) is written to history at waddr, and waddr increments (wraps mod window).
- Output: 2-entry skid buffer. out_valid/out_data hold stable while out_ready=0.
- Throughput is 1 byte/cycle with out_ready=1.
- Literal latency: byte appears at the output 1 cycle after its stream_ack.
- Copy latency: first byte appears 2 cycles after LEN ack.
- COPY returns to PROC when the remaining length is 0 and all reads have landed.
- stream_ack is never asserted without stream_valid, and never in COPY, END or ERR.
- END: out_done=1 after the skid buffer drains. Stays until ce=0, then IDLE.
- ERR: err=1 and no acks or outputs. Leaves only on rst, or ce=0 (goes to IDLE, clears err).
- ce=0 mid-frame: complete the current token and copy, then go to IDLE. Undrained output bytes still deliver.

Optional Feature:
LZS_DEC_STATS_EN:
- Defined: adds outputs stat_bytes[31:0] (bytes output this frame) and stat_tokens[31:0] (literals plus matches). Both clear on IDLE entry.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package lzs_dec_pkg: state enum; err_code constants; token prefix constants (END_MARK=9'b110000000); IN_W derivation function; length-table constants 2..8.
- Sub-module lzs_hist_ram: simple dual-port RAM, 2^HIST_AW x 8, sync write, sync read, with same-cycle write-to-read bypass.

Test Plan:
- Literals 0x41, 0x42, then END; out_ready=1 -> out_data 41, 42 on consecutive cycles; out_done=1; total acks 9+9+9.
- "AB" then match offset 2, length 4 (short form) -> output ABABAB, six bytes.
- Literal 0x5A then offset 1, length 23 (LEN2=11, nibble 15, nibble 0) -> 24 bytes of 5A; bypass exercised.
- Match offset 0 -> err=1, err_code=01, no further stream_ack.
- 3 literals then offset 4 -> err_code=10.
- Copy of 8 with out_ready toggling 1010... -> 8 bytes correct and in order; out_data stable while stalled.
- rst asserted mid-COPY -> all outputs 0 next edge; after ce, a fresh frame decodes correctly.

Source files
------------

// File: rtl/lzs_dec_pkg.sv
// Shared types and constants for the LZS decode engine: FSM states, error codes,
// token prefixes, match-length table and the stream width derivation.
package lzs_dec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PROC,
        LEN1,
        LEN2,
        LENX,
        COPY,
        END,
        ERR
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_OFF_ZERO = 2'b01;
    localparam logic [1:0] ERR_OFF_FAR  = 2'b10;
    localparam logic [1:0] ERR_LEN_OVF  = 2'b11;

    localparam logic [8:0] END_MARK  = 9'b110000000;
    localparam logic [1:0] PFX_SHORT = 2'b11;

    localparam int LEN_BASE1 = 2;
    localparam int LEN_BASE2 = 5;
    localparam int LEN_EXT   = 8;

    function automatic int in_w(input int hist_aw);
        return hist_aw + 2;
    endfunction

endpackage

// File: rtl/lzs_hist_ram.sv
// History window: 2^HIST_AW x 8 simple dual-port RAM, one-cycle read latency,
// with a same-cycle write-to-read bypass so overlapping copies see fresh bytes.
module lzs_hist_ram
    import lzs_dec_pkg::*;
#(
    parameter int HIST_AW = 11
) (
    input  logic               clk,
    input  logic               we,
    input  logic [HIST_AW-1:0] waddr,
    input  logic [7:0]         wdata,
    input  logic               re,
    input  logic [HIST_AW-1:0] raddr,
    output logic [7:0]         rdata
);

    logic [7:0] mem [0:(1 << HIST_AW) - 1];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/lzs_decode_engine.sv
// LZS token-stream decoder with sliding history window and 2-entry output skid buffer.
// Per-frame statistics ports are added when LZS_DEC_STATS_EN is defined.
module lzs_decode_engine
    import lzs_dec_pkg::*;
#(
    parameter int  HIST_AW = 11,
    parameter int  LEN_W   = 16,
    localparam int IN_W    = in_w(HIST_AW)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic [IN_W-1:0] stream_data,
    input  logic            stream_valid,
    output logic [3:0]      stream_width,
    output logic            stream_ack,
    output logic [7:0]      out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_done,
    output logic            err,
    output logic [1:0]      err_code
`ifdef LZS_DEC_STATS_EN
    ,
    output logic [31:0]     stat_bytes,
    output logic [31:0]     stat_tokens
`endif
);

    localparam logic [HIST_AW:0] WIN_CNT = {1'b1, {HIST_AW{1'b0}}};

    state_t             state, state_nx;
    logic [HIST_AW-1:0] waddr, rptr, offset_q, tok_off, rd_base, ram_raddr;
    logic [HIST_AW:0]   wcount;
    logic [LEN_W-1:0]   len_q, len_val;
    logic [LEN_W:0]     len_sum;
    logic [1:0]         cnt, code2;
    logic [2:0]         occ;
    logic [7:0]         buf0, buf1, push_data, ram_rdata;
    logic [8:0]         top9;
    logic [3:0]         nib;
    logic               rd_vld_p1, push, pop, room;
    logic               lit_push, mt_load, to_copy, len_ld, rd_issue, err_set;
    logic [1:0]         err_val;

    assign top9    = stream_data[IN_W-1 -: 9];
    assign code2   = stream_data[IN_W-1 -: 2];
    assign nib     = stream_data[IN_W-1 -: 4];
    assign tok_off = (code2 == PFX_SHORT) ? {{(HIST_AW-7){1'b0}}, stream_data[IN_W-3 -: 7]}
                                          : stream_data[HIST_AW-1:0];
    assign len_sum = {1'b0, len_q} + {{(LEN_W-3){1'b0}}, nib};
    assign rd_base = waddr - offset_q;

    // Skid occupancy after this edge, counting a read that lands now; new work needs a free slot.
    assign out_valid = (cnt != 2'd0);
    assign out_data  = out_valid ? buf0 : 8'h00;
    assign pop       = out_valid && out_ready;
    assign occ       = {1'b0, cnt} + {2'b00, rd_vld_p1} - {2'b00, pop};
    assign room      = (occ < 3'd2);
    assign push      = lit_push || rd_vld_p1;
    assign push_data = rd_vld_p1 ? ram_rdata : stream_data[IN_W-2 -: 8];
    assign ram_raddr = (state == COPY) ? rptr : rd_base;
    assign out_done  = (state == END) && !out_valid;
    assign err       = (state == ERR);

    always_comb begin
        state_nx     = state;
        stream_ack   = 1'b0;
        stream_width = 4'd0;
        lit_push     = 1'b0;
        mt_load      = 1'b0;
        to_copy      = 1'b0;
        len_ld       = 1'b0;
        len_val      = '0;
        rd_issue     = 1'b0;
        err_set      = 1'b0;
        err_val      = ERR_NONE;
        unique case (state)
            IDLE: if (ce) state_nx = PROC;
            PROC: begin
                if (!ce)
                    state_nx = IDLE;
                else if (stream_valid && room) begin
                    stream_ack   = 1'b1;
                    stream_width = 4'd9;
                    if (top9 == END_MARK)
                        state_nx = END;
                    else if (!stream_data[IN_W-1])
                        lit_push = 1'b1;
                    else begin
                        if (code2 != PFX_SHORT)
                            stream_width = 4'(IN_W);
                        if (tok_off == '0) begin
                            err_set = 1'b1;
                            err_val = ERR_OFF_ZERO;
                        end else if ({1'b0, tok_off} > wcount) begin
                            err_set = 1'b1;
                            err_val = ERR_OFF_FAR;
                        end else begin
                            mt_load  = 1'b1;
                            state_nx = LEN1;
                        end
                    end
                end
            end
            LEN1: if (stream_valid) begin
                stream_ack   = 1'b1;
                stream_width = 4'd2;
                if (code2 != 2'b11) begin
                    to_copy = 1'b1;
                    len_val = LEN_W'(LEN_BASE1) + LEN_W'(code2);
                end else
                    state_nx = LEN2;
            end
            LEN2: if (stream_valid) begin
                stream_ack   = 1'b1;
                stream_width = 4'd2;
                if (code2 != 2'b11) begin
                    to_copy = 1'b1;
                    len_val = LEN_W'(LEN_BASE2) + LEN_W'(code2);
                end else begin
                    len_ld   = 1'b1;
                    len_val  = LEN_W'(LEN_EXT);
                    state_nx = LENX;
                end
            end
            LENX: if (stream_valid) begin
                stream_ack   = 1'b1;
                stream_width = 4'd4;
                len_val      = len_sum[LEN_W-1:0];
                if (len_sum[LEN_W]) begin
                    err_set = 1'b1;
                    err_val = ERR_LEN_OVF;
                end else if (nib == 4'hF)
                    len_ld = 1'b1;
                else
                    to_copy = 1'b1;
            end
            COPY: begin
                if (len_q != '0)
                    rd_issue = room;
                else
                    state_nx = PROC;
            end
            END: if (!ce) state_nx = IDLE;
            ERR: if (!ce) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // The first history read goes out with the final length ack.
        if (to_copy) begin
            state_nx = COPY;
            rd_issue = room;
        end
        if (err_set)
            state_nx = ERR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            waddr     <= '0;
            wcount    <= '0;
            rd_vld_p1 <= 1'b0;
            len_q     <= '0;
            rptr      <= '0;
            err_code  <= ERR_NONE;
        end else begin
            state     <= state_nx;
            rd_vld_p1 <= rd_issue;
            if (state_nx == ERR && state != ERR)
                cnt <= 2'd0;
            else
                cnt <= cnt + {1'b0, push} - {1'b0, pop};
            if (push) begin
                waddr <= waddr + 1'b1;
                if (wcount != WIN_CNT)
                    wcount <= wcount + 1'b1;
            end
            if (state == IDLE && state_nx == PROC)
                wcount <= '0;
            if (to_copy)
                len_q <= len_val - LEN_W'(rd_issue);
            else if (len_ld)
                len_q <= len_val;
            else if (rd_issue)
                len_q <= len_q - 1'b1;
            if (to_copy)
                rptr <= rd_base + HIST_AW'(rd_issue);
            else if (rd_issue)
                rptr <= rptr + 1'b1;
            if (err_set)
                err_code <= err_val;
            else if (state == ERR && state_nx == IDLE)
                err_code <= ERR_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (mt_load)
            offset_q <= tok_off;
        unique case ({push, pop})
            2'b10: if (cnt == 2'd0) buf0 <= push_data; else buf1 <= push_data;
            2'b01: buf0 <= buf1;
            2'b11: begin
                if (cnt == 2'd1)
                    buf0 <= push_data;
                else begin
                    buf0 <= buf1;
                    buf1 <= push_data;
                end
            end
            default: ;
        endcase
    end

`ifdef LZS_DEC_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_bytes  <= '0;
            stat_tokens <= '0;
        end else if (state != IDLE && state_nx == IDLE) begin
            stat_bytes  <= '0;
            stat_tokens <= '0;
        end else begin
            if (pop)
                stat_bytes <= stat_bytes + 1'b1;
            if (lit_push || mt_load)
                stat_tokens <= stat_tokens + 1'b1;
        end
    end
`endif

    lzs_hist_ram #(.HIST_AW(HIST_AW)) u_hist (
        .clk   (clk),
        .we    (push),
        .waddr (waddr),
        .wdata (push_data),
        .re    (rd_issue),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_lzs_decode_engine.sv
// Directed testbench for lzs_decode_engine: a bit-shifter model feeds hand-encoded
// token streams and decoded bytes are compared against hand-computed expectations.
module tb_lzs_decode_engine;
    import lzs_dec_pkg::*;

    localparam int HIST_AW = 11;
    localparam int LEN_W   = 16;
    localparam int IN_W    = in_w(HIST_AW);

    logic            clk = 1'b0;
    logic            rst, ce, stream_valid, stream_ack, out_valid, out_ready, out_done, err;
    logic [IN_W-1:0] stream_data;
    logic [3:0]      stream_width;
    logic [7:0]      out_data;
    logic [1:0]      err_code;
`ifdef LZS_DEC_STATS_EN
    logic [31:0]     stat_bytes, stat_tokens;
`endif

    lzs_decode_engine #(.HIST_AW(HIST_AW), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .ce           (ce),
        .stream_data  (stream_data),
        .stream_valid (stream_valid),
        .stream_width (stream_width),
        .stream_ack   (stream_ack),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_done     (out_done),
        .err          (err),
        .err_code     (err_code)
`ifdef LZS_DEC_STATS_EN
        ,
        .stat_bytes   (stat_bytes),
        .stat_tokens  (stat_tokens)
`endif
    );

    always #5 clk = ~clk;

    bit         bits [0:1023];
    int         nbits = 0;
    int         pos = 0;
    int         cyc = 0;
    int         ngot = 0;
    logic [7:0] got [0:63];
    int         got_cyc [0:63];
    int         ack_bits = 0;
    int         first_ack_cyc = -1;
    int         len_ack_cyc = -1;
    int         viol = 0;
    int         stall_err = 0;
    logic       clr = 1'b1;
    logic       tog_en = 1'b0;
    logic       tog = 1'b0;
    logic       prev_v = 1'b0, prev_r = 1'b0;
    logic [7:0] prev_d = 8'h00;
    int         passed = 0;
    int         total = 0;

    always_comb begin
        stream_data = '0;
        for (int i = 0; i < IN_W; i++)
            if (pos + i < nbits)
                stream_data[IN_W-1-i] = bits[pos+i];
    end
    assign stream_valid = (pos + IN_W <= nbits);
    assign out_ready    = tog_en ? tog : 1'b1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        tog <= ~tog;
        if (clr) begin
            pos           <= 0;
            ngot          <= 0;
            ack_bits      <= 0;
            first_ack_cyc <= -1;
            len_ack_cyc   <= -1;
            viol          <= 0;
        end else begin
            if (stream_ack) begin
                pos      <= pos + int'(stream_width);
                ack_bits <= ack_bits + int'(stream_width);
                if (first_ack_cyc < 0)
                    first_ack_cyc <= cyc;
                if (stream_width == 4'd2 && len_ack_cyc < 0)
                    len_ack_cyc <= cyc;
                if (!stream_valid || err)
                    viol <= viol + 1;
            end
            if (out_valid && out_ready && ngot < 64) begin
                got[ngot]     <= out_data;
                got_cyc[ngot] <= cyc;
                ngot          <= ngot + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (clr) begin
            stall_err <= 0;
        end else if (prev_v && !prev_r && (!out_valid || out_data !== prev_d)) begin
            stall_err <= stall_err + 1;
        end
        prev_v <= out_valid;
        prev_r <= out_ready;
        prev_d <= out_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic put(input int n, input logic [15:0] v);
        for (int i = n - 1; i >= 0; i--) begin
            bits[nbits] = v[i];
            nbits++;
        end
    endtask

    task automatic lit(input logic [7:0] b);
        put(1, 16'd0);
        put(8, {8'h00, b});
    endtask

    task automatic mshort(input int off);
        put(2, 16'd3);
        put(7, 16'(off));
    endtask

    task automatic mlong(input int off);
        put(2, 16'd2);
        put(HIST_AW, 16'(off));
    endtask

    task automatic endm();
        put(9, {7'd0, END_MARK});
        put(IN_W, 16'd0);
    endtask

    task automatic reset_dut();
        rst    = 1'b1;
        ce     = 1'b0;
        clr    = 1'b1;
        tog_en = 1'b0;
        nbits  = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic wait_flag(input string tag, input int budget, input bit want_err);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(posedge clk);
            #1;
            hit = want_err ? err : out_done;
        end
        chk(tag, {31'd0, hit}, 32'd1);
    endtask

    task automatic stream_ab_then_end();
        lit(8'h41);
        lit(8'h42);
        endm();
    endtask

    task automatic stream_5a_run();
        lit(8'h5A);
        mshort(1);
        put(2, 16'd3);
        put(2, 16'd3);
        put(4, 16'd15);
        put(4, 16'd0);
        endm();
    endtask

    initial begin
        int   bad;
        bit   hit;
        logic [7:0] e;

        rst = 1'b1;
        ce  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_stream_ack", {31'd0, stream_ack}, 32'd0);
        chk("rst_out_done", {31'd0, out_done}, 32'd0);
        chk("rst_err", {30'd0, err_code}, 32'd0);

        // Two literals then end marker.
        reset_dut();
        stream_ab_then_end();
        ce = 1'b1;
        wait_flag("t1_done_timeout", 100, 1'b0);
        chk("t1_count", ngot, 32'd2);
        chk("t1_byte0", {24'd0, got[0]}, 32'h41);
        chk("t1_byte1", {24'd0, got[1]}, 32'h42);
        chk("t1_back_to_back", got_cyc[1] - got_cyc[0], 32'd1);
        chk("t1_lit_latency", got_cyc[0] - first_ack_cyc, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("t1_ack_bits", ack_bits, 32'd27);
        chk("t1_done_hold", {31'd0, out_done}, 32'd1);
        chk("t1_no_err", {31'd0, err}, 32'd0);

        // "AB" then short match offset 2 length 4.
        reset_dut();
        lit(8'h41);
        lit(8'h42);
        mshort(2);
        put(2, 16'd2);
        endm();
        ce = 1'b1;
        wait_flag("t2_done_timeout", 100, 1'b0);
        chk("t2_count", ngot, 32'd6);
        for (int i = 0; i < 6; i++) begin
            e = (i % 2 == 0) ? 8'h41 : 8'h42;
            chk($sformatf("t2_byte%0d", i), {24'd0, got[i]}, {24'd0, e});
        end
        chk("t2_copy_latency", got_cyc[2] - len_ack_cyc, 32'd2);

        // Offset 1, length 23 replicates one byte through the bypass.
        reset_dut();
        stream_5a_run();
        ce = 1'b1;
        wait_flag("t3_done_timeout", 200, 1'b0);
        chk("t3_count", ngot, 32'd24);
        bad = 0;
        for (int i = 0; i < 24; i++)
            if (got[i] !== 8'h5A) bad++;
        chk("t3_bad_bytes", bad, 32'd0);
        chk("t3_ack_bits", ack_bits, 32'd39);
        chk("t3_rate", got_cyc[23] - got_cyc[1], 32'd22);

        // Offset zero is a frame error.
        reset_dut();
        mlong(0);
        put(IN_W, 16'd0);
        ce = 1'b1;
        wait_flag("t4_err_timeout", 50, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("t4_err", {31'd0, err}, 32'd1);
        chk("t4_err_code", {30'd0, err_code}, 32'd1);
        chk("t4_ack_bits", ack_bits, 32'd13);
        chk("t4_ack_viol", viol, 32'd0);
        chk("t4_no_out", {31'd0, out_valid}, 32'd0);
        ce = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t4_err_clear", {31'd0, err}, 32'd0);
        chk("t4_code_clear", {30'd0, err_code}, 32'd0);

        // Offset past the bytes written so far.
        reset_dut();
        lit(8'h01);
        lit(8'h02);
        lit(8'h03);
        mshort(4);
        put(IN_W, 16'd0);
        ce = 1'b1;
        wait_flag("t5_err_timeout", 50, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_err_code", {30'd0, err_code}, 32'd2);
        chk("t5_ack_bits", ack_bits, 32'd36);

        // Copy of 8 under alternating backpressure.
        reset_dut();
        tog_en = 1'b1;
        lit(8'h11);
        lit(8'h22);
        lit(8'h33);
        mshort(3);
        put(2, 16'd3);
        put(2, 16'd3);
        put(4, 16'd0);
        endm();
        ce = 1'b1;
        wait_flag("t6_done_timeout", 200, 1'b0);
        chk("t6_count", ngot, 32'd11);
        bad = 0;
        for (int i = 0; i < 11; i++) begin
            e = (i % 3 == 0) ? 8'h11 : ((i % 3 == 1) ? 8'h22 : 8'h33);
            if (got[i] !== e) bad++;
        end
        chk("t6_bad_bytes", bad, 32'd0);
        chk("t6_stall_stable", stall_err, 32'd0);
        chk("t6_ack_viol", viol, 32'd0);

        // Asynchronous reset in the middle of a copy, then a fresh frame.
        reset_dut();
        stream_5a_run();
        ce  = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge clk);
            #1;
            hit = (ngot >= 5);
        end
        chk("t7_copy_started", {31'd0, hit}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t7_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t7_rst_data", {24'd0, out_data}, 32'd0);
        chk("t7_rst_ack", {27'd0, stream_ack, stream_width}, 32'd0);
        chk("t7_rst_flags", {29'd0, out_done, err_code}, 32'd0);
        reset_dut();
        stream_ab_then_end();
        ce = 1'b1;
        wait_flag("t7_done_timeout", 100, 1'b0);
        chk("t7_count", ngot, 32'd2);
        chk("t7_byte0", {24'd0, got[0]}, 32'h41);
        chk("t7_byte1", {24'd0, got[1]}, 32'h42);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
